// File: rtl/line_reverser.sv
// Line reversal stage between the RX FIFO and the TX FIFO.
// Buffers one text line, then on the terminator writes it back byte-reversed
// followed by CR LF, honouring downstream backpressure.
module line_reverser #(
    parameter int unsigned              WORD_WIDTH = 8,
    parameter int unsigned              MAX_LEN    = 64,
    parameter logic [WORD_WIDTH-1:0]    TERM_CHAR  = WORD_WIDTH'(8'h0A),
    parameter logic [WORD_WIDTH-1:0]    DROP_CHAR  = WORD_WIDTH'(8'h0D)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WORD_WIDTH-1:0] din,
    input  logic                  empty,
    output logic                  re,
    output logic [WORD_WIDTH-1:0] dout,
    output logic                  wr_en,
    input  logic                  full,
    output logic                  busy,
    output logic                  overflow
);

    localparam int unsigned CW = $clog2(MAX_LEN + 1);
    localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [CW-1:0]         MAX_CNT = CW'(MAX_LEN);
    localparam logic [WORD_WIDTH-1:0] CR_BYTE = WORD_WIDTH'(8'h0D);
    localparam logic [WORD_WIDTH-1:0] LF_BYTE = WORD_WIDTH'(8'h0A);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_EMIT,
        S_EMIT_CR,
        S_EMIT_LF
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         count_q, count_d;
    logic [CW-1:0]         idx_q,   idx_d;
    logic [WORD_WIDTH-1:0] dout_q,  dout_d;
    logic                  busy_q,  busy_d;

    logic                  re_c;
    logic                  wr_en_c;
    logic                  overflow_c;
    logic                  mem_we;

    logic [WORD_WIDTH-1:0] line_mem [MAX_LEN];

    // State and registered-output flops
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
            idx_q   <= '0;
            dout_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            dout_q  <= dout_d;
            busy_q  <= busy_d;
        end
    end

    // Line buffer storage; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            line_mem[AW'(count_q)] <= din;
        end
    end

    // Next-state and strobe decode; dout is prefetched so it is valid with wr_en
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        idx_d      = idx_q;
        dout_d     = dout_q;
        re_c       = 1'b0;
        wr_en_c    = 1'b0;
        overflow_c = 1'b0;
        mem_we     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    re_c    = 1'b1;
                    state_d = S_CAPTURE;
                end
            end

            S_CAPTURE: begin
                if (din == TERM_CHAR) begin
                    idx_d = count_q;
                    if (count_q == '0) begin
                        dout_d  = CR_BYTE;
                        state_d = S_EMIT_CR;
                    end else begin
                        dout_d  = line_mem[AW'(count_q - CW'(1))];
                        state_d = S_EMIT;
                    end
                end else if (din == DROP_CHAR) begin
                    state_d = S_IDLE;
                end else if (count_q < MAX_CNT) begin
                    mem_we  = 1'b1;
                    count_d = count_q + CW'(1);
                    state_d = S_IDLE;
                end else begin
                    overflow_c = 1'b1;
                    state_d    = S_IDLE;
                end
            end

            S_EMIT: begin
                if (!full) begin
                    wr_en_c = 1'b1;
                    idx_d   = idx_q - CW'(1);
                    if (idx_q == CW'(1)) begin
                        dout_d  = CR_BYTE;
                        state_d = S_EMIT_CR;
                    end else begin
                        dout_d = line_mem[AW'(idx_q - CW'(2))];
                    end
                end
            end

            S_EMIT_CR: begin
                if (!full) begin
                    wr_en_c = 1'b1;
                    dout_d  = LF_BYTE;
                    state_d = S_EMIT_LF;
                end
            end

            S_EMIT_LF: begin
                if (!full) begin
                    wr_en_c = 1'b1;
                    count_d = '0;
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_EMIT) || (state_d == S_EMIT_CR) || (state_d == S_EMIT_LF);
    end

    // FIFO strobes must react within the cycle to empty/full; re is also held off during reset
    assign re       = re_c & rst;
    assign wr_en    = wr_en_c;
    assign overflow = overflow_c;
    assign dout     = dout_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_line_reverser.sv
// Bench for line_reverser: RX FIFO model feeding the DUT, TX sink collecting
// writes, and a line-level reference model computing the expected byte stream.
module tb_line_reverser;

    localparam int unsigned MAX_LEN = 8;

    typedef logic [7:0] bq_t[$];

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] din = 8'h00;
    logic       empty = 1'b1;
    logic       full = 1'b0;
    logic       re;
    logic [7:0] dout;
    logic       wr_en;
    logic       busy;
    logic       overflow;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    bq_t rx_q;
    bq_t out_q;
    bit  pop_req = 1'b0;
    bit  bp_mode = 1'b0;
    int  ovf_seen = 0;
    int  wr_full_viol = 0;
    int  rw_viol = 0;
    int  busy_viol = 0;
    int  first_wr = -1;
    int  last_wr = -1;
    int  term_re = -1;

    line_reverser #(
        .WORD_WIDTH (8),
        .MAX_LEN    (MAX_LEN)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .empty    (empty),
        .re       (re),
        .dout     (dout),
        .wr_en    (wr_en),
        .full     (full),
        .busy     (busy),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // RX FIFO, standard mode: data appears the cycle after re
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (pop_req && rx_q.size() > 0) begin
            din <= rx_q.pop_front();
        end
        empty <= (rx_q.size() == 0);
    end

    // Mid-cycle monitor: TX sink, overflow pulses, protocol rules
    always @(negedge clk) begin
        pop_req = re;
        if (re && rx_q.size() > 0 && rx_q[0] == 8'h0A && term_re < 0) term_re = cyc;
        if (overflow) ovf_seen++;
        if (wr_en) begin
            out_q.push_back(dout);
            if (first_wr < 0) first_wr = cyc;
            last_wr = cyc;
            if (full) wr_full_viol++;
            if (!busy) busy_viol++;
        end
        if (re && wr_en) rw_viol++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (bp_mode) full = ($urandom_range(0, 2) == 0);
    endtask

    // Reference: reverse each line, drop CR, cap at MAX_LEN bytes, append CR LF
    function automatic void model(input bq_t s, output bq_t o, output int ovf);
        bq_t line;
        o = {};
        ovf = 0;
        foreach (s[i]) begin
            if (s[i] == 8'h0A) begin
                for (int j = line.size() - 1; j >= 0; j--) o.push_back(line[j]);
                o.push_back(8'h0D);
                o.push_back(8'h0A);
                line = {};
            end else if (s[i] == 8'h0D) begin
                continue;
            end else if (line.size() < MAX_LEN) begin
                line.push_back(s[i]);
            end else begin
                ovf++;
            end
        end
    endfunction

    task automatic run(input string tag, input bq_t stim, input bit chk_timing, input int stall_after);
        bq_t exp;
        int  exp_ovf;
        bit  done;
        bit  stalled;
        model(stim, exp, exp_ovf);
        out_q.delete();
        ovf_seen = 0;
        first_wr = -1;
        term_re  = -1;
        foreach (stim[i]) rx_q.push_back(stim[i]);
        done = 1'b0;
        stalled = 1'b0;
        for (int c = 0; c < 4000 && !done; c++) begin
            step();
            if (stall_after >= 0 && !stalled && out_q.size() >= stall_after) begin
                full = 1'b1;
                repeat (10) step();
                check({tag, " stall_hold"}, 32'(out_q.size()), 32'(stall_after));
                full = 1'b0;
                stalled = 1'b1;
            end
            done = (out_q.size() >= exp.size()) && (rx_q.size() == 0) && empty && !busy;
        end
        check({tag, " done"}, 32'(done), 32'd1);
        repeat (2) step();
        check({tag, " len"}, 32'(out_q.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            check($sformatf("%s byte%0d", tag, i),
                  (i < out_q.size()) ? 32'(out_q[i]) : 32'hFFFF_FFFF, 32'(exp[i]));
        end
        check({tag, " ovf"}, 32'(ovf_seen), 32'(exp_ovf));
        if (chk_timing) begin
            check({tag, " latency"}, 32'(first_wr - term_re), 32'd2);
            check({tag, " span"}, 32'(last_wr - first_wr + 1), 32'(exp.size()));
        end
    endtask

    initial begin
        bq_t s;
        bit  reached;
        int  n;
        logic [7:0] b;

        // Reset state
        rst = 1'b0;
        repeat (3) step();
        check("reset_strobes", 32'({re, wr_en, busy, overflow}), 32'd0);
        check("reset_dout", 32'(dout), 32'd0);
        rst = 1'b1;
        step();

        // Basic line, empty line, dropped CR
        s = '{8'h61, 8'h62, 8'h63, 8'h0A};
        run("abc", s, 1'b1, -1);
        check("abc busy_after", 32'(busy), 32'd0);
        check("abc empty_after", 32'(empty), 32'd1);
        s = '{8'h0A};
        run("empty_line", s, 1'b1, -1);
        s = '{8'h61, 8'h62, 8'h0D, 8'h0A};
        run("ab_cr", s, 1'b1, -1);

        // Overflow: 10 data bytes into an 8-byte buffer
        s = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 8'h69, 8'h6A, 8'h0A};
        run("overflow", s, 1'b0, -1);
        check("overflow count", 32'(ovf_seen), 32'd2);

        // Exactly full buffer, no overflow
        s = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h0A};
        run("exact_full", s, 1'b1, -1);

        // Backpressure window after the second output byte
        s = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h0A};
        run("hello_bp", s, 1'b0, 2);

        // Reset during emit
        s = '{8'h77, 8'h78, 8'h79, 8'h7A, 8'h0A};
        out_q.delete();
        foreach (s[i]) rx_q.push_back(s[i]);
        reached = 1'b0;
        for (int c = 0; c < 200 && !reached; c++) begin
            step();
            reached = (out_q.size() >= 1);
        end
        check("rst_mid reached_emit", 32'(reached), 32'd1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("rst_mid strobes", 32'({re, wr_en, busy, overflow}), 32'd0);
        check("rst_mid dout", 32'(dout), 32'd0);
        n = out_q.size();
        repeat (3) step();
        check("rst_mid no_write_in_reset", 32'(out_q.size()), 32'(n));
        rst = 1'b1;
        repeat (3) step();
        check("rst_mid no_write_after", 32'(out_q.size()), 32'(n));
        s = '{8'h71, 8'h0A};
        run("after_reset", s, 1'b1, -1);

        // Randomized multi-line traffic with random backpressure
        for (int r = 0; r < 4; r++) begin
            s = {};
            for (int l = 0; l < 6; l++) begin
                int len;
                len = $urandom_range(0, 11);
                for (int k = 0; k < len; k++) begin
                    if ($urandom_range(0, 9) == 0) begin
                        b = 8'h0D;
                    end else begin
                        b = 8'($urandom_range(0, 255));
                        if (b == 8'h0A || b == 8'h0D) b = 8'h41;
                    end
                    s.push_back(b);
                end
                s.push_back(8'h0A);
            end
            bp_mode = 1'b1;
            run($sformatf("rand%0d", r), s, 1'b0, -1);
            bp_mode = 1'b0;
            full = 1'b0;
            step();
        end

        // Protocol rules over the whole run
        check("wr_en_while_full", 32'(wr_full_viol), 32'd0);
        check("re_and_wr_en", 32'(rw_viol), 32'd0);
        check("wr_en_without_busy", 32'(busy_viol), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
